// File: rtl/mealy_serial_tx.sv
// Strobe/data serial transmitter: each bit goes out as a MARK cycle
// followed by a DATA cycle, LSB first, with optional idle gap per word.
module mealy_serial_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             C,
  input  logic             aR,
  input  logic [WIDTH-1:0] Din,
  input  logic             Valid,
  output logic             Ready,
  output logic             S,
  output logic             D,
  output logic             Busy,
  output logic [1:0]       StateQ
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [7:0] GLOAD = 8'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    DATA = 2'd2,
    GAPS = 2'd3
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]   bitCnt;
  logic [7:0]      gapCnt;

  always_ff @(posedge C or negedge aR) begin
    if (!aR) begin
      state  <= IDLE;
      shift  <= '0;
      bitCnt <= '0;
      gapCnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Valid) begin
            shift  <= Din;
            bitCnt <= '0;
            state  <= MARK;
          end
        end
        MARK: state <= DATA;
        DATA: begin
          if (bitCnt < LAST) begin
            shift  <= shift >> 1;
            bitCnt <= bitCnt + 1'b1;
            state  <= MARK;
          end else if (GAP > 0) begin
            gapCnt <= GLOAD;
            state  <= GAPS;
          end else begin
            state <= IDLE;
          end
        end
        GAPS: begin
          if (gapCnt == 8'd0) begin
            state <= IDLE;
          end else begin
            gapCnt <= gapCnt - 8'd1;
          end
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state: no input-to-output path.
  assign S      = (state == MARK);
  assign D      = (state == DATA) & shift[0];
  assign Ready  = (state == IDLE);
  assign Busy   = ~Ready;
  assign StateQ = state;

endmodule

// File: doc/mealy_serial_tx.md
# mealy_serial_tx

Serial transmitter for the two-wire strobe/data (S, D) link decoded by the team's Mealy-machine receiver. Accepts a parallel word over a valid/ready handshake and emits each bit as a two-cycle symbol: a mark cycle (S=1, D=0) followed by a data cycle (S=0, D=bit). The receiver then pulses its R output once per bit with Y equal to the bit. It sits upstream of the receiver, either on the same board or in loopback for self-test.

## Interface
- WIDTH, 8: bits per word; legal range 1..32.
- GAP, 0: idle cycles (S=0, D=0) inserted after each word; legal range 0..255.

- C  input  1  clock, rising edge active.
- aR  input  1  reset; one clock, reset is asynchronous and active-low.
- Din  input  WIDTH  parallel word; sampled only on accept.
- Valid  input  1  Din is valid.
- Ready  output  1  transmitter can accept a word.
- S  output  1  link strobe.
- D  output  1  link data.
- Busy  output  1  word in flight, including the GAP phase.
- StateQ  output  2  current state code, for debug.

## Operation
- States and codes: IDLE=0, MARK=1, DATA=2, GAP=3.
- IDLE: Ready=1 and S=D=0. If Valid=1 at a rising edge of C:
  - load the shift register with Din;
  - clear the bit counter;
  - go to MARK.
- MARK: S=1, D=0. Always go to DATA on the next edge.
- DATA: S=0, D=shift[0].
  - If bit counter < WIDTH-1: shift right by one, increment the counter, go to MARK.
  - Else: if GAP>0, load the gap counter with GAP-1 and go to GAP; otherwise go to IDLE.
- GAP: S=D=0. Decrement the gap counter; go to IDLE when it is 0.
- Bit order is LSB first.
- Outputs are decoded directly from registered state; there is no combinational path from any input to any output:
  - S = (state==MARK);
  - D = (state==DATA) & shift[0];
  - Ready = (state==IDLE);
  - Busy = !Ready.
- Valid while Ready=0 is ignored. Din changes during a word have no effect.
- Bit counter width is clog2(WIDTH), minimum 1. The gap counter is 8 bits. No wrap: the counter never exceeds WIDTH-1.

## Timing
- Reset asserted (aR=0), taking effect immediately and asynchronously:
  - state=IDLE and StateQ=0;
  - S=0, D=0, Ready=1, Busy=0;
  - shift register and all counters cleared.
- Reset release: first accept possible at the first rising edge with aR=1 and Valid=1.
- Accept at edge k:
  - MARK of bit 0 is visible in cycle k+1.
  - Bit i occupies cycles k+1+2i (MARK) and k+2+2i (DATA).
  - The last DATA cycle is k+2·WIDTH.
  - Ready returns in cycle k+2·WIDTH+1+GAP.
- Throughput: one word per 2·WIDTH+GAP+1 cycles with Valid held high. The IDLE cycle between words is mandatory.
- Receiver side: R=1 with Y=bit in each DATA cycle, once per bit.
- Reset mid-word: S and D drop to 0 asynchronously and the word is abandoned.
  - If reset lands while in MARK, the receiver sees a falling S and emits one spurious bit (Y=0).
  - The link partner must be reset together with this block; no recovery is attempted.

## Test plan
- Reset: assert aR=0 with Valid=1 and Din=8'hFF -> S=0, D=0, Ready=1, Busy=0, StateQ=0 throughout. No accept occurs until aR=1.
- Single word (WIDTH=8, GAP=0): Din=8'hA5, Valid pulsed at edge 0.
  - S=1 on cycles 1,3,…,15.
  - D on cycles 2,4,…,16 = 1,0,1,0,0,1,0,1.
  - Ready=1 again at cycle 17.
- Back-to-back: Valid held high with Din=8'h01 then 8'h80 -> second MARK starts at cycle 18. The D streams are 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1.
- GAP=3, Din=8'h0F -> S=D=0 for cycles 17–19, StateQ=3 during those cycles, Ready=1 at cycle 20. Valid toggled during the word is ignored.
- Reset mid-word: aR=0 during the DATA cycle of bit 3 -> S=D=0 at once and StateQ=0. A new word 8'h3C after release transmits correctly from bit 0.
- Loopback into the receiver with random words and WIDTH in {1, 8, 32} -> the receiver pulses R exactly WIDTH times per word, and the Y sequence LSB-first reassembles Din.
